skip_monitor: RTL and testbench
===============================

Name: skip_monitor

Overview:
- Downstream consumer of the skip-ring clock generator: samples the skipped clock (SCLK) and the ring-position-0 marker (B0) in the mCLK domain.
- Counts SCLK pulses and mCLK cycles per ring revolution and reports them to a reader through a VALID/READY capture register.
- Flags revolutions whose pulse count differs from the expected count, and declares lock after consecutive matching revolutions.
- Used for self-check of skip masks and to drive status LEDs.

Parameters:
- CW, 8: width of the pulse counter, EXP and COUNT.
- PW, 32: width of the revolution-period counter (mCLK cycles).
- SYNC, 2: synchronizer depth for SCLK and B0 (minimum 2).
- LOCKN, 2: consecutive matching revolutions required to assert LOCK (minimum 1).

Ports:
- mCLK  in  1  system clock; all state on posedge.
- RST  in  1  reset, synchronous, active-high.
- SCLK  in  1  skipped clock from the ring, asynchronous to mCLK.
- B0  in  1  ring bit-0 marker; its rising edge starts a revolution. Asynchronous.
- EXP  in  CW  expected SCLK pulses per revolution; sampled at each revolution boundary.
- READY  in  1  reader accepts the capture register.
- VALID  out  1  capture register holds unread data.
- COUNT  out  CW  SCLK rising edges in the last captured revolution.
- PERIOD  out  PW  mCLK cycles in the last captured revolution.
- MISMATCH  out  1  last captured COUNT != EXP.
- LOCK  out  1  LOCKN consecutive revolutions matched.
- OVR  out  1  sticky: a revolution was dropped because VALID was still set.

Behaviour:
- Reset: VALID, COUNT, PERIOD, MISMATCH, LOCK and OVR are all 0. Sync chains clear to 0. FSM enters IDLE. Internal counters are 0.
- Synchronizers: SYNC flops per input, followed by one history flop. Edge pulse = sync_out & ~hist.
  - A transition sampled at mCLK edge k produces an edge pulse in the cycle after edge k+SYNC-1.
  - Registered outputs update at edge k+SYNC.
- FSM IDLE: counters are held at 0. On a B0 edge: go to RUN, set pcnt=0, set per=1. Nothing is captured.
- FSM RUN, every cycle:
  - per increments, saturating at all-ones.
  - An SCLK edge increments pcnt, saturating at 2^CW-1.
- FSM RUN, on a B0 edge (revolution boundary):
  - Candidate values: cnt = pcnt plus 1 if an SCLK edge occurs in the same cycle; per = current per.
  - Capture rule:
    - If VALID=0, or VALID=1 with READY=1 in the same cycle: load COUNT=cnt, PERIOD=per, MISMATCH=(cnt!=EXP); VALID=1.
    - Otherwise the old data is kept and OVR is set.
  - Restart: pcnt=0, per=1. A same-cycle SCLK edge belongs to the closing revolution, not the new one.
- Lock tracking, per revolution boundary, independent of capture/drop:
  - A match increments a run counter, saturating at LOCKN. LOCK is 1 when the run counter equals LOCKN.
  - A mismatch clears the run counter and LOCK at the same edge.
- Handshake:
  - VALID&READY with no boundary in that cycle: VALID=0 next cycle. COUNT and PERIOD hold their values.
  - READY while VALID=0 has no effect.
- OVR: cleared only by RST.
- Wrap/saturation:
  - A saturated pcnt is reported as 2^CW-1 and compared normally.
  - A saturated per is reported as all-ones.
- Reset mid-revolution: partial counts are discarded and the FSM returns to IDLE. The first revolution after reset is never reported.
- B0 edges closer than 1 cycle apart cannot occur after synchronization. No special case is needed.

Decomposition:
- Shared package skip_pkg holds:
  - state enum {IDLE, RUN};
  - constants DEF_SYNC=2, DEF_CW=8;
  - function popcount, for bench and top-level EXP derivation.
- One sub-module: skip_edge_sync (SYNC-deep synchronizer plus rising-edge pulse), instantiated twice (SCLK, B0).

Test Plan:
- Basic capture: RST 4 cycles; B0 rises every 160 mCLK with 6 SCLK pulses between; EXP=6, READY=1 → after 2nd B0 edge, VALID pulses with COUNT=6, PERIOD=160, MISMATCH=0. LOCK=1 after the 2nd reported revolution; no report before the first full revolution.
- Mismatch: EXP=5, same stimulus → MISMATCH=1 every revolution, LOCK stays 0. Then EXP=6 → LOCK after 2 revolutions. Then one revolution with 7 pulses → LOCK drops at that boundary.
- Overrun: READY=0 for 3 revolutions → COUNT/PERIOD hold the first revolution's values, OVR=1. READY=1 → VALID drops next cycle; OVR stays 1 until RST.
- Simultaneous edges: SCLK and B0 rise on the same mCLK edge → that pulse is counted in the closing revolution (COUNT=6, not 5); the next revolution also reports 6.
- Saturation: CW=4, 20 pulses per revolution → COUNT=15; PW=8, 300-cycle revolution → PERIOD=255.
- Reset mid-operation: assert RST halfway through a revolution → all outputs 0 next cycle. The next B0 edge gives no VALID; the one after reports a full revolution.

Source files
------------

// File: rtl/skip_pkg.sv
// Shared types and helpers for the skip-ring monitor.
// Holds the FSM state enum, default widths and a popcount helper.
package skip_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam int DEF_SYNC = 2;
  localparam int DEF_CW   = 8;

  // Number of set bits in a skip mask, i.e. the
  // expected SCLK pulses per ring revolution.
  function automatic int unsigned popcount(
    input logic [31:0] v
  );
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/skip_edge_sync.sv
// SYNC-deep synchronizer followed by a history flop.
// Ports: clk, rst (sync, active-high), d (async in), pulse (rising-edge strobe).
module skip_edge_sync
  import skip_pkg::*;
#(
  parameter int SYNC = DEF_SYNC
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic [SYNC-1:0] sr;
  logic            hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr   <= '0;
      hist <= 1'b0;
    end else begin
      sr   <= {sr[SYNC-2:0], d};
      hist <= sr[SYNC-1];
    end
  end

  assign pulse = sr[SYNC-1] & ~hist;

endmodule

// File: rtl/skip_monitor.sv
// Counts SCLK pulses and mCLK cycles per B0 revolution, reports via VALID/READY.
// Ports: mCLK, RST, SCLK, B0, EXP, READY -> VALID, COUNT, PERIOD, MISMATCH, LOCK, OVR.
module skip_monitor
  import skip_pkg::*;
#(
  parameter int CW    = DEF_CW,
  parameter int PW    = 32,
  parameter int SYNC  = DEF_SYNC,
  parameter int LOCKN = 2
) (
  input  logic          mCLK,
  input  logic          RST,
  input  logic          SCLK,
  input  logic          B0,
  input  logic [CW-1:0] EXP,
  input  logic          READY,
  output logic          VALID,
  output logic [CW-1:0] COUNT,
  output logic [PW-1:0] PERIOD,
  output logic          MISMATCH,
  output logic          LOCK,
  output logic          OVR
);

  localparam int RW = $clog2(LOCKN + 1);
  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [PW-1:0] PMAX = '1;
  localparam logic [RW-1:0] RMAX = RW'(LOCKN);

  logic          sclk_e;
  logic          b0_e;
  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] pcnt;
  logic [PW-1:0] per;
  logic [RW-1:0] run_q;
  logic [RW-1:0] run_d;
  logic [CW-1:0] cnt_c;
  logic          bnd;
  logic          match;
  logic          load;

  skip_edge_sync #(.SYNC(SYNC)) u_sclk (
    .clk   (mCLK),
    .rst   (RST),
    .d     (SCLK),
    .pulse (sclk_e)
  );

  skip_edge_sync #(.SYNC(SYNC)) u_b0 (
    .clk   (mCLK),
    .rst   (RST),
    .d     (B0),
    .pulse (b0_e)
  );

  always_ff @(posedge mCLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    bnd     = 1'b0;
    unique case (state_q)
      IDLE: if (b0_e) state_d = RUN;
      RUN:  bnd = b0_e;
      default: state_d = IDLE;
    endcase
  end

  // A same-cycle SCLK edge closes out with the old
  // revolution, so it is folded in before the compare.
  always_comb begin
    cnt_c = pcnt;
    if (sclk_e && pcnt != CMAX) cnt_c = pcnt + 1'b1;
    match = (cnt_c == EXP);
    run_d = '0;
    if (match) begin
      run_d = (run_q == RMAX) ? run_q : run_q + 1'b1;
    end
    load = bnd && (!VALID || READY);
  end

  always_ff @(posedge mCLK) begin
    if (RST) begin
      pcnt     <= '0;
      per      <= '0;
      run_q    <= '0;
      VALID    <= 1'b0;
      COUNT    <= '0;
      PERIOD   <= '0;
      MISMATCH <= 1'b0;
      LOCK     <= 1'b0;
      OVR      <= 1'b0;
    end else begin
      if (state_q == IDLE) begin
        pcnt <= '0;
        per  <= b0_e ? PW'(1) : '0;
      end else if (bnd) begin
        pcnt <= '0;
        per  <= PW'(1);
      end else begin
        pcnt <= cnt_c;
        if (per != PMAX) per <= per + 1'b1;
      end

      if (load) begin
        VALID    <= 1'b1;
        COUNT    <= cnt_c;
        PERIOD   <= per;
        MISMATCH <= !match;
      end else if (bnd) begin
        OVR <= 1'b1;
      end else if (VALID && READY) begin
        VALID <= 1'b0;
      end

      // Lock follows every boundary, even dropped ones.
      if (bnd) begin
        run_q <= run_d;
        LOCK  <= (run_d == RMAX);
      end
    end
  end

endmodule

// File: tb/tb_skip_monitor.sv
// Directed bench for skip_monitor: default instance plus a CW=4/PW=8 one.
// Stimulus: B0 revolutions with SCLK pulse trains, sampled on negedge.
module tb_skip_monitor;
  import skip_pkg::*;

  logic       mCLK = 1'b0;
  logic       RST;
  logic       SCLK;
  logic       B0;
  logic       READY;
  logic [7:0] EXP;
  logic [3:0] EXP2;

  logic        VALID, MISMATCH, LOCK, OVR;
  logic [7:0]  COUNT;
  logic [31:0] PERIOD;
  logic        VALID2, MISMATCH2, LOCK2, OVR2;
  logic [3:0]  COUNT2;
  logic [7:0]  PERIOD2;

  int checks = 0;
  int errors = 0;

  logic        s_v, s_v4, s_m, s_l, s_o;
  logic [7:0]  s_c;
  logic [31:0] s_p;
  logic [3:0]  s_c2;
  logic [7:0]  s_p2;
  logic        s_m2;

  always #5 mCLK = ~mCLK;

  skip_monitor dut (
    .mCLK     (mCLK),
    .RST      (RST),
    .SCLK     (SCLK),
    .B0       (B0),
    .EXP      (EXP),
    .READY    (READY),
    .VALID    (VALID),
    .COUNT    (COUNT),
    .PERIOD   (PERIOD),
    .MISMATCH (MISMATCH),
    .LOCK     (LOCK),
    .OVR      (OVR)
  );

  skip_monitor #(.CW(4), .PW(8)) dut2 (
    .mCLK     (mCLK),
    .RST      (RST),
    .SCLK     (SCLK),
    .B0       (B0),
    .EXP      (EXP2),
    .READY    (READY),
    .VALID    (VALID2),
    .COUNT    (COUNT2),
    .PERIOD   (PERIOD2),
    .MISMATCH (MISMATCH2),
    .LOCK     (LOCK2),
    .OVR      (OVR2)
  );

  // One revolution: B0 rises at c=0; n SCLK pulses from c=10.
  // lead adds a pulse rising together with B0.
  // Snapshot at c=3 sees the capture of the previous revolution.
  task automatic rev(input bit lead, input int n, input int len);
    int sp;
    sp = (len - 20) / n;
    for (int c = 0; c < len; c++) begin
      @(negedge mCLK);
      if (c == 3) begin
        s_v = VALID; s_c = COUNT; s_p = PERIOD;
        s_m = MISMATCH; s_l = LOCK; s_o = OVR;
        s_c2 = COUNT2; s_p2 = PERIOD2; s_m2 = MISMATCH2;
      end
      if (c == 4) s_v4 = VALID;
      B0   = (c < 4);
      SCLK = (lead && c < 3) ||
             (c >= 10 && ((c - 10) % sp) < 3 &&
              ((c - 10) / sp) < n);
    end
  endtask

  task automatic test_reset;
    RST = 1'b1; SCLK = 1'b0; B0 = 1'b0;
    READY = 1'b1;
    EXP = 8'(popcount(32'h0000_003F));
    EXP2 = 4'd6;
    repeat (4) @(negedge mCLK);
    checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", VALID); end
    checks++; if (COUNT !== 8'd0) begin errors++; $display("FAIL rst_count got %0d want 0", COUNT); end
    checks++; if (PERIOD !== 32'd0) begin errors++; $display("FAIL rst_period got %0d want 0", PERIOD); end
    checks++; if (MISMATCH !== 1'b0) begin errors++; $display("FAIL rst_mis got %b want 0", MISMATCH); end
    checks++; if (LOCK !== 1'b0) begin errors++; $display("FAIL rst_lock got %b want 0", LOCK); end
    checks++; if (OVR !== 1'b0) begin errors++; $display("FAIL rst_ovr got %b want 0", OVR); end
    RST = 1'b0;
  endtask

  task automatic test_basic;
    rev(0, 6, 160);
    checks++; if (s_v !== 1'b0) begin errors++; $display("FAIL first_no_report got %b want 0", s_v); end
    rev(0, 6, 160);
    checks++; if (s_v !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", s_v); end
    checks++; if (s_c !== 8'd6) begin errors++; $display("FAIL basic_count got %0d want 6", s_c); end
    checks++; if (s_p !== 32'd160) begin errors++; $display("FAIL basic_period got %0d want 160", s_p); end
    checks++; if (s_m !== 1'b0) begin errors++; $display("FAIL basic_mis got %b want 0", s_m); end
    checks++; if (s_l !== 1'b0) begin errors++; $display("FAIL basic_lock1 got %b want 0", s_l); end
    checks++; if (s_v4 !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %b want 0", s_v4); end
    rev(0, 6, 160);
    checks++; if (s_l !== 1'b1) begin errors++; $display("FAIL basic_lock2 got %b want 1", s_l); end
  endtask

  task automatic test_mismatch;
    EXP = 8'(popcount(32'h0000_001F));
    rev(0, 6, 160);
    checks++; if (s_m !== 1'b1) begin errors++; $display("FAIL mis_a got %b want 1", s_m); end
    checks++; if (s_l !== 1'b0) begin errors++; $display("FAIL mis_lock_a got %b want 0", s_l); end
    rev(0, 6, 160);
    checks++; if (s_m !== 1'b1) begin errors++; $display("FAIL mis_b got %b want 1", s_m); end
    checks++; if (s_l !== 1'b0) begin errors++; $display("FAIL mis_lock_b got %b want 0", s_l); end
    EXP = 8'd6;
    rev(0, 6, 160);
    checks++; if (s_m !== 1'b0) begin errors++; $display("FAIL relock_mis got %b want 0", s_m); end
    checks++; if (s_l !== 1'b0) begin errors++; $display("FAIL relock_1 got %b want 0", s_l); end
    rev(0, 7, 160);
    checks++; if (s_l !== 1'b1) begin errors++; $display("FAIL relock_2 got %b want 1", s_l); end
    rev(0, 6, 160);
    checks++; if (s_c !== 8'd7) begin errors++; $display("FAIL seven_count got %0d want 7", s_c); end
    checks++; if (s_m !== 1'b1) begin errors++; $display("FAIL seven_mis got %b want 1", s_m); end
    checks++; if (s_l !== 1'b0) begin errors++; $display("FAIL lock_drop got %b want 0", s_l); end
  endtask

  task automatic test_overrun;
    READY = 1'b0;
    rev(0, 5, 200);
    checks++; if (s_v !== 1'b1) begin errors++; $display("FAIL ovr_load got %b want 1", s_v); end
    checks++; if (s_o !== 1'b0) begin errors++; $display("FAIL ovr_early got %b want 0", s_o); end
    rev(0, 5, 200);
    checks++; if (s_c !== 8'd6) begin errors++; $display("FAIL ovr_hold_c got %0d want 6", s_c); end
    checks++; if (s_p !== 32'd160) begin errors++; $display("FAIL ovr_hold_p got %0d want 160", s_p); end
    checks++; if (s_o !== 1'b1) begin errors++; $display("FAIL ovr_set got %b want 1", s_o); end
    rev(0, 6, 160);
    checks++; if (s_c !== 8'd6) begin errors++; $display("FAIL ovr_hold_c2 got %0d want 6", s_c); end
    checks++; if (s_p !== 32'd160) begin errors++; $display("FAIL ovr_hold_p2 got %0d want 160", s_p); end
    checks++; if (s_v !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b want 1", s_v); end
    READY = 1'b1;
    @(negedge mCLK);
    checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL ovr_read got %b want 0", VALID); end
    checks++; if (OVR !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", OVR); end
  endtask

  task automatic test_simultaneous;
    rev(0, 5, 160);
    rev(1, 6, 160);
    checks++; if (s_c !== 8'd6) begin errors++; $display("FAIL sim_close got %0d want 6", s_c); end
    checks++; if (s_m !== 1'b0) begin errors++; $display("FAIL sim_mis got %b want 0", s_m); end
    rev(0, 6, 160);
    checks++; if (s_c !== 8'd6) begin errors++; $display("FAIL sim_next got %0d want 6", s_c); end
    checks++; if (OVR !== 1'b1) begin errors++; $display("FAIL ovr_still got %b want 1", OVR); end
  endtask

  task automatic test_saturation;
    EXP  = 8'(popcount(32'h000F_FFFF));
    EXP2 = 4'(popcount(32'h0000_7FFF));
    rev(0, 20, 300);
    rev(0, 6, 160);
    checks++; if (s_c !== 8'd20) begin errors++; $display("FAIL wide_count got %0d want 20", s_c); end
    checks++; if (s_p !== 32'd300) begin errors++; $display("FAIL wide_period got %0d want 300", s_p); end
    checks++; if (s_c2 !== 4'd15) begin errors++; $display("FAIL sat_count got %0d want 15", s_c2); end
    checks++; if (s_p2 !== 8'd255) begin errors++; $display("FAIL sat_period got %0d want 255", s_p2); end
    checks++; if (s_m2 !== 1'b0) begin errors++; $display("FAIL sat_mis got %b want 0", s_m2); end
  endtask

  task automatic test_reset_mid;
    EXP = 8'd6;
    rev(0, 6, 160);
    rev(0, 3, 80);
    RST = 1'b1;
    @(negedge mCLK);
    RST = 1'b0;
    checks++; if (COUNT !== 8'd0) begin errors++; $display("FAIL mid_count got %0d want 0", COUNT); end
    checks++; if (PERIOD !== 32'd0) begin errors++; $display("FAIL mid_period got %0d want 0", PERIOD); end
    checks++; if (OVR !== 1'b0) begin errors++; $display("FAIL mid_ovr got %b want 0", OVR); end
    checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", VALID); end
    checks++; if (LOCK !== 1'b0) begin errors++; $display("FAIL mid_lock got %b want 0", LOCK); end
    rev(0, 6, 160);
    checks++; if (s_v !== 1'b0) begin errors++; $display("FAIL mid_first got %b want 0", s_v); end
    rev(0, 6, 160);
    checks++; if (s_v !== 1'b1) begin errors++; $display("FAIL mid_valid2 got %b want 1", s_v); end
    checks++; if (s_c !== 8'd6) begin errors++; $display("FAIL mid_count2 got %0d want 6", s_c); end
    checks++; if (s_p !== 32'd160) begin errors++; $display("FAIL mid_period2 got %0d want 160", s_p); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_mismatch;
    test_overrun;
    test_simultaneous;
    test_saturation;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
